// File: rtl/wave_capture_pkg.sv
// Shared encodings for the waveform capture sequencer.
// State codes and the offset-binary conversion for display samples.
package wave_capture_pkg;

    typedef enum logic [1:0] {
        ST_ARM     = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_DONE    = 2'b10
    } cap_state_t;

    localparam logic [7:0] SAMPLE_OFFSET = 8'h80;

    function automatic logic [7:0] to_display(input logic [7:0] hi);
        return hi ^ SAMPLE_OFFSET;
    endfunction

endpackage

// File: rtl/wave_capture_ctrl_edge_detect.sv
// Single-flop rising-edge detector used for the display vsync.
// rise is combinational: high in the cycle the level first reads 1.
module wave_capture_ctrl_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_d;

    always_ff @(posedge clk) begin
        if (reset) level_d <= 1'b0;
        else       level_d <= level;
    end

    assign rise = level && !level_d;

endmodule

// File: rtl/wave_capture_ctrl.sv
// Ping-pong waveform capture: decimate, trigger on +zero-crossing, fill a bank.
// Optional WAVE_CAPTURE_AUTOTRIG_EN forces a trigger after AUTO_TRIG_COUNT idle samples.
module wave_capture_ctrl
    import wave_capture_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DECIM           = 1,
    parameter int AUTO_TRIG_COUNT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample,
    input  logic [15:0]           sample,
    input  logic                  vsync,
    output logic                  wr_en,
    output logic [ADDR_WIDTH:0]   wr_addr,
    output logic [7:0]            wr_data,
    output logic                  read_bank,
    output logic [1:0]            state
);

    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = '1;

    cap_state_t            st;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DEC_W-1:0]      dec_cnt;
    logic                  prev_neg;
    logic                  vsync_rise;
    logic                  accepted;
    logic                  trigger;
    logic                  fire;

    assign accepted = new_sample && (dec_cnt == '0);
    assign trigger  = accepted && prev_neg && !sample[15];
    assign state    = st;

    wave_capture_ctrl_edge_detect u_vsync_edge (
        .clk   (clk),
        .reset (reset),
        .level (vsync),
        .rise  (vsync_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_cnt <= '0;
        end else if (new_sample) begin
            dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
        end
    end

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    localparam int ARM_W = $clog2(AUTO_TRIG_COUNT + 1);

    logic [ARM_W-1:0] arm_cnt;
    logic             arm_full;
    logic             unused_cfg;

    assign arm_full   = (arm_cnt == ARM_W'(AUTO_TRIG_COUNT));
    assign fire       = trigger || (accepted && arm_full);
    assign unused_cfg = ^sample[7:0];

    // Held at zero outside ARM, so it is clear on every entry to ARM.
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt <= '0;
        end else if (st != ST_ARM || fire) begin
            arm_cnt <= '0;
        end else if (accepted) begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign fire       = trigger;
    assign unused_cfg = ^sample[7:0] ^ (AUTO_TRIG_COUNT != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= ST_ARM;
            idx       <= '0;
            prev_neg  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            read_bank <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (accepted) prev_neg <= sample[15];
            unique case (st)
                ST_ARM: begin
                    if (fire) begin
                        wr_en   <= 1'b1;
                        wr_addr <= {~read_bank, {ADDR_WIDTH{1'b0}}};
                        wr_data <= to_display(sample[15:8]);
                        idx     <= ADDR_WIDTH'(1);
                        st      <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (accepted) begin
                        wr_en   <= 1'b1;
                        wr_addr <= {~read_bank, idx};
                        wr_data <= to_display(sample[15:8]);
                        if (idx == IDX_LAST) begin
                            idx <= '0;
                            st  <= ST_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // A sample arriving with the swap cannot trigger this cycle.
                    if (vsync_rise) begin
                        read_bank <= ~read_bank;
                        st        <= ST_ARM;
                    end
                end
                default: st <= ST_ARM;
            endcase
        end
    end

endmodule
